pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the MIPS CPU fetch stage. It holds the PC register and produces the sequential increment. It arbitrates exception, ERET, jump and branch redirects by fixed priority, and parks redirects that arrive while fetch is stalled. It also traps misaligned redirect targets to the exception vector.

## Interface
- WIDTH, 32, PC width in bits
- STEP, 4, sequential increment; power of two, at least 1
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
- EXC_VECTOR, 32'h0000_0080, PC value loaded by exception or address error

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold the PC this cycle
- br_taken  in  1  branch redirect request
- br_target  in  WIDTH  branch target
- jump  in  1  jump redirect request
- jump_target  in  WIDTH  jump target
- eret  in  1  return from exception
- epc  in  WIDTH  ERET target
- exc  in  1  exception; load EXC_VECTOR
- pc  out  WIDTH  current fetch address (registered)
- pc_plus  out  WIDTH  pc + STEP (combinational)
- addr_err  out  1  one-cycle pulse: a misaligned target was trapped
- pending  out  1  a parked redirect is waiting for stall to drop

## Operation
- Reset (rst_n low, asynchronous):
  - pc = RESET_VECTOR
  - pending = 0, parked target cleared
  - addr_err = 0
- Arithmetic: pc_plus = (pc + STEP) mod 2^WIDTH; wrap-around is silent, with no flag.
- Request priority each cycle is exc > eret > jump > br_taken > parked target > sequential.
- exc:
  - Always taken, even when stall = 1.
  - pc <= EXC_VECTOR; the parked redirect is discarded and pending <= 0.
- Registered behaviour while stall = 0:
  - The selected target is loaded into pc; if nothing is selected, pc <= pc_plus.
  - The parked target is consumed (pending <= 0) when it is selected.
  - The parked target is also discarded when a higher-priority request (eret, jump, br_taken) wins that cycle.
- Registered behaviour while stall = 1 and exc = 0:
  - pc holds its value.
  - If eret, jump or br_taken is asserted, the highest-priority one is parked and pending <= 1.
  - A later stalled request overwrites an earlier parked one; the newest request wins.
- Misalignment check:
  - Applies to the target actually loaded from eret, jump, br_taken or the parked register.
  - Misaligned means any of the low log2(STEP) bits is nonzero.
  - A misaligned target loads pc <= EXC_VECTOR and pulses addr_err = 1 for exactly one cycle.
  - Parked targets are checked when consumed, not when parked.
  - STEP = 1 disables the check.
- State machine:
  - RUN (pending = 0) -> PARKED on a redirect while stalled.
  - PARKED -> RUN when the parked target is consumed, overridden, or hit by exc.
  - PARKED -> PARKED when a newer redirect overwrites the parked target.
  - Any state -> RUN on reset.

## Timing
- All requests are sampled on the rising clk edge; pc changes on that same edge, so the redirect latency is 1 cycle.
- A parked target loads on the first edge with stall = 0, which is 1 cycle after stall drops.
- pending and addr_err are registered; addr_err is high in the cycle following the offending edge.
- pc_plus follows pc combinationally within the same cycle.
- Reset asserted mid-stall or while PARKED clears all state immediately; the first edge after release produces RESET_VECTOR + STEP.

## Test plan
- Reset then 3 free-running cycles -> pc = 0x0, 0x4, 0x8, 0xC; pending = 0; addr_err = 0.
- pc = 0x40, jump = 1 with jump_target = 0x100 and br_taken = 1 with br_target = 0x200 in the same cycle -> next pc = 0x100 (jump wins over branch).
- Hold stall = 1 for 3 cycles at pc = 0x20:
  - br_taken with br_target = 0x300 in cycle 1, then jump with jump_target = 0x500 in cycle 2.
  - Required: pc stays at 0x20; pending = 1; after stall drops, pc = 0x500, then 0x504.
- At pc = 0x20 with a parked target 0x300 and stall = 1, pulse exc -> next pc = 0x80 and pending = 0; after stall drops, pc = 0x84 (the parked target is not used).
- br_taken with br_target = 0x102 -> pc = 0x80 and addr_err high for exactly one cycle; the next cycle gives pc = 0x84 with addr_err = 0.
- WIDTH = 8, STEP = 4, pc = 0xFC, free-running -> pc = 0x00 with no flag.
- Assert rst_n low mid-PARKED -> pc = RESET_VECTOR immediately, pending = 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for the MIPS fetch stage. It holds the PC register
// and generates the sequential increment. It arbitrates redirects by fixed
// priority: exc > eret > jump > br_taken > parked target > sequential. A
// redirect that arrives while fetch is stalled is parked until stall drops. A
// misaligned redirect target is trapped to EXC_VECTOR.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   stall        in   hold the PC this cycle (exc still taken)
//   br_taken     in   branch redirect request, target br_target
//   jump         in   jump redirect request, target jump_target
//   eret         in   return from exception, target epc
//   exc          in   exception, load EXC_VECTOR
//   pc           out  current fetch address (registered)
//   pc_plus      out  pc + STEP, wraps silently (combinational)
//   addr_err     out  one-cycle pulse after a misaligned target was trapped
//   pending      out  a parked redirect is waiting for stall to drop
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int                WIDTH        = 32,
   parameter int                STEP         = 4,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(32'h0000_0000),
   parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0080)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             eret,
   input  logic [WIDTH-1:0] epc,
   input  logic             exc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic             addr_err,
   output logic             pending
);

   // STEP is a power of two, so the low log2(STEP) bits are STEP-1.
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_PARKED = 1'b1
   } state_t;

   state_t           state_q,    state_d;
   logic [WIDTH-1:0] pc_q,       pc_d;
   logic [WIDTH-1:0] park_q,     park_d;
   logic             addr_err_q, addr_err_d;

   logic             redir_s;
   logic [WIDTH-1:0] redir_tgt_s;

   // A target is misaligned when any bit below the step granularity is set.
   function automatic logic misaligned(input logic [WIDTH-1:0] tgt);
      if (STEP == 1) begin
         misaligned = 1'b0;
      end else begin
         misaligned = |(tgt & ALIGN_MASK);
      end
   endfunction

   // Sequential increment; modulo 2^WIDTH by truncation.
   assign pc_plus = pc_q + WIDTH'(STEP);

   // Priority selection among live requests and the parked target.
   always_comb begin
      redir_s     = 1'b0;
      redir_tgt_s = pc_plus;
      if (eret) begin
         redir_s     = 1'b1;
         redir_tgt_s = epc;
      end else if (jump) begin
         redir_s     = 1'b1;
         redir_tgt_s = jump_target;
      end else if (br_taken) begin
         redir_s     = 1'b1;
         redir_tgt_s = br_target;
      end else if (state_q == ST_PARKED) begin
         redir_s     = 1'b1;
         redir_tgt_s = park_q;
      end else begin
         redir_s     = 1'b0;
         redir_tgt_s = pc_plus;
      end
   end

   // Next-state computation for pc, parked target, FSM state and error pulse.
   always_comb begin
      pc_d       = pc_q;
      park_d     = park_q;
      state_d    = state_q;
      addr_err_d = 1'b0;
      if (exc) begin
         // Exception wins even over stall and drops any parked redirect.
         pc_d    = EXC_VECTOR;
         park_d  = '0;
         state_d = ST_RUN;
      end else if (stall) begin
         // Only live requests are parked; the newest one overwrites the old.
         // A stalled cycle with no live request leaves any parked target alone.
         if (eret || jump || br_taken) begin
            park_d  = redir_tgt_s;
            state_d = ST_PARKED;
         end else begin
            park_d  = park_q;
            state_d = state_q;
         end
      end else begin
         // Unstalled: the parked target is either consumed or overridden.
         park_d  = '0;
         state_d = ST_RUN;
         if (redir_s && misaligned(redir_tgt_s)) begin
            pc_d       = EXC_VECTOR;
            addr_err_d = 1'b1;
         end else if (redir_s) begin
            pc_d = redir_tgt_s;
         end else begin
            pc_d = pc_plus;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         park_q     <= '0;
         state_q    <= ST_RUN;
         addr_err_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         park_q     <= park_d;
         state_q    <= state_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign pc       = pc_q;
   assign addr_err = addr_err_q;
   assign pending  = (state_q == ST_PARKED);

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed vector table, hand-written reset/wrap sequences and a randomized
// run against a behavioural model of the pc_sequencer.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, br_taken = 1'b0, jump = 1'b0, eret = 1'b0, exc = 1'b0;
   logic [31:0] br_target = '0, jump_target = '0, epc = '0;
   logic [31:0] pc, pc_plus;
   logic        addr_err, pending;

   // 8-bit instance for the wrap-around case
   logic        jump8 = 1'b0;
   logic [7:0]  jt8 = '0;
   logic        zero1 = 1'b0;
   logic [7:0]  zero8 = '0;
   logic [7:0]  pc8, pc_plus8;
   logic        addr_err8, pending8;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .br_taken(br_taken), .br_target(br_target),
      .jump(jump), .jump_target(jump_target),
      .eret(eret), .epc(epc), .exc(exc),
      .pc(pc), .pc_plus(pc_plus), .addr_err(addr_err), .pending(pending)
   );

   pc_sequencer #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'h00), .EXC_VECTOR(8'h80)) dut8 (
      .clk(clk), .rst_n(rst_n), .stall(zero1),
      .br_taken(zero1), .br_target(zero8),
      .jump(jump8), .jump_target(jt8),
      .eret(zero1), .epc(zero8), .exc(zero1),
      .pc(pc8), .pc_plus(pc_plus8), .addr_err(addr_err8), .pending(pending8)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        stall, br, jmp, ert, ex;
      logic [31:0] brt, jt, ep;
      logic [31:0] exp_pc;
      logic        exp_pend, exp_err;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt_i,
                               input logic e, input logic [31:0] ep_i, input logic x,
                               input logic [31:0] p, input logic pd, input logic er);
      vec_t v;
      v.stall = s; v.br = b; v.brt = bt; v.jmp = j; v.jt = jt_i;
      v.ert = e; v.ep = ep_i; v.ex = x;
      v.exp_pc = p; v.exp_pend = pd; v.exp_err = er;
      return v;
   endfunction

   task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt_i,
                        input logic e, input logic [31:0] ep_i, input logic x);
      stall = s; br_taken = b; br_target = bt; jump = j; jump_target = jt_i;
      eret = e; epc = ep_i; exc = x;
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] m_pc;
   logic [31:0] m_park[$];
   logic        m_err;

   task automatic model_step();
      logic [31:0] cand_t[$];
      logic        cand_v[$];
      logic        found;
      logic [31:0] tgt;
      cand_v = '{eret, jump, br_taken};
      cand_t = '{epc, jump_target, br_target};
      found = 1'b0; tgt = '0;
      m_err = 1'b0;
      if (exc) begin
         m_pc = 32'h80;
         m_park.delete();
      end else if (stall) begin
         for (int i = 0; i < 3; i++)
            if (!found && cand_v[i]) begin found = 1'b1; tgt = cand_t[i]; end
         if (found) begin
            m_park.delete();
            m_park.push_back(tgt);
         end
      end else begin
         if (m_park.size() != 0) begin
            cand_v.push_back(1'b1);
            cand_t.push_back(m_park[0]);
         end
         for (int i = 0; i < cand_v.size(); i++)
            if (!found && cand_v[i]) begin found = 1'b1; tgt = cand_t[i]; end
         m_park.delete();
         if (!found) m_pc = m_pc + 32'd4;
         else if (tgt % 4 != 0) begin m_pc = 32'h80; m_err = 1'b1; end
         else m_pc = tgt;
      end
   endtask

   vec_t tbl[25];

   initial begin
      tbl[0]  = mk(0,0,0,          0,0,          0,0,        0, 32'h4,   0,0);
      tbl[1]  = mk(0,0,0,          0,0,          0,0,        0, 32'h8,   0,0);
      tbl[2]  = mk(0,0,0,          0,0,          0,0,        0, 32'hC,   0,0);
      tbl[3]  = mk(0,0,0,          1,32'h40,     0,0,        0, 32'h40,  0,0);
      tbl[4]  = mk(0,1,32'h200,    1,32'h100,    0,0,        0, 32'h100, 0,0);
      tbl[5]  = mk(0,0,0,          1,32'h20,     0,0,        0, 32'h20,  0,0);
      tbl[6]  = mk(1,1,32'h300,    0,0,          0,0,        0, 32'h20,  1,0);
      tbl[7]  = mk(1,0,0,          1,32'h500,    0,0,        0, 32'h20,  1,0);
      tbl[8]  = mk(1,0,0,          0,0,          0,0,        0, 32'h20,  1,0);
      tbl[9]  = mk(0,0,0,          0,0,          0,0,        0, 32'h500, 0,0);
      tbl[10] = mk(0,0,0,          0,0,          0,0,        0, 32'h504, 0,0);
      tbl[11] = mk(0,0,0,          1,32'h20,     0,0,        0, 32'h20,  0,0);
      tbl[12] = mk(1,1,32'h300,    0,0,          0,0,        0, 32'h20,  1,0);
      tbl[13] = mk(1,0,0,          0,0,          0,0,        1, 32'h80,  0,0);
      tbl[14] = mk(1,0,0,          0,0,          0,0,        0, 32'h80,  0,0);
      tbl[15] = mk(0,0,0,          0,0,          0,0,        0, 32'h84,  0,0);
      tbl[16] = mk(0,1,32'h102,    0,0,          0,0,        0, 32'h80,  0,1);
      tbl[17] = mk(0,0,0,          0,0,          0,0,        0, 32'h84,  0,0);
      tbl[18] = mk(0,0,0,          1,32'h2000,   1,32'h1000, 0, 32'h1000,0,0);
      tbl[19] = mk(0,0,0,          0,0,          1,32'h1000, 1, 32'h80,  0,0);
      tbl[20] = mk(1,0,0,          1,32'h203,    0,0,        0, 32'h80,  1,0);
      tbl[21] = mk(0,0,0,          0,0,          0,0,        0, 32'h80,  0,1);
      tbl[22] = mk(1,1,32'h400,    0,0,          0,0,        0, 32'h80,  1,0);
      tbl[23] = mk(0,1,32'h600,    0,0,          0,0,        0, 32'h600, 0,0);
      tbl[24] = mk(0,0,0,          0,0,          0,0,        0, 32'h604, 0,0);

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      chk("reset_pc_in_reset", pc, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("reset_pc", pc, 32'h0);
      chk("reset_pc_plus", pc_plus, 32'h4);
      chk("reset_pending", {31'd0, pending}, 32'd0);
      chk("reset_addr_err", {31'd0, addr_err}, 32'd0);

      // ---------------- directed vector table ----------------
      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].stall, tbl[i].br, tbl[i].brt, tbl[i].jmp, tbl[i].jt,
               tbl[i].ert, tbl[i].ep, tbl[i].ex);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
         chk($sformatf("vec%0d_pc_plus", i), pc_plus, tbl[i].exp_pc + 32'd4);
         chk($sformatf("vec%0d_pending", i), {31'd0, pending}, {31'd0, tbl[i].exp_pend});
         chk($sformatf("vec%0d_addr_err", i), {31'd0, addr_err}, {31'd0, tbl[i].exp_err});
         @(negedge clk);
      end

      // ---------------- reset while PARKED ----------------
      drive(1, 0, 0, 1, 32'h700, 0, 0, 0);
      @(posedge clk); #1;
      chk("park_before_reset_pending", {31'd0, pending}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_reset_pc", pc, 32'h0);
      chk("async_reset_pending", {31'd0, pending}, 32'd0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("after_reset_pc", pc, 32'h4);
      chk("after_reset_pending", {31'd0, pending}, 32'd0);
      @(negedge clk);

      // ---------------- 8-bit wrap-around ----------------
      jump8 = 1'b1; jt8 = 8'hFC;
      @(posedge clk); #1;
      chk("w8_pc_fc", {24'd0, pc8}, 32'hFC);
      chk("w8_pc_plus_wrap", {24'd0, pc_plus8}, 32'h00);
      @(negedge clk);
      jump8 = 1'b0;
      @(posedge clk); #1;
      chk("w8_pc_wrap", {24'd0, pc8}, 32'h00);
      chk("w8_no_flag", {31'd0, addr_err8}, 32'd0);
      @(negedge clk);

      // ---------------- randomized run vs model ----------------
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_pc = 32'h0; m_park.delete(); m_err = 1'b0;
      for (int n = 0; n < 600; n++) begin
         stall       = ($urandom_range(0, 99) < 35);
         exc         = ($urandom_range(0, 99) < 5);
         eret        = ($urandom_range(0, 99) < 8);
         jump        = ($urandom_range(0, 99) < 12);
         br_taken    = ($urandom_range(0, 99) < 15);
         epc         = $urandom & 32'h0000_FFFF;
         jump_target = $urandom & 32'h0000_FFFF;
         br_target   = $urandom & 32'h0000_FFFF;
         // Mostly aligned targets, with a steady trickle of misaligned ones.
         if ($urandom_range(0, 3) != 0) epc         = epc & ~32'h3;
         if ($urandom_range(0, 3) != 0) jump_target = jump_target & ~32'h3;
         if ($urandom_range(0, 3) != 0) br_target   = br_target & ~32'h3;
         model_step();
         @(posedge clk); #1;
         chk($sformatf("rnd%0d_pc", n), pc, m_pc);
         chk($sformatf("rnd%0d_pc_plus", n), pc_plus, m_pc + 32'd4);
         chk($sformatf("rnd%0d_pending", n), {31'd0, pending},
             (m_park.size() != 0) ? 32'd1 : 32'd0);
         chk($sformatf("rnd%0d_addr_err", n), {31'd0, addr_err}, {31'd0, m_err});
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
